// File: rtl/seven_segment_mux_counter.sv
`default_nettype none
// ============================================================================
// Module  : seven_segment_mux_counter
// Brief   : Prescaled hex/BCD up/down counter with parallel load, wrap pulse
//           and a time-multiplexed, leading-zero-blanked 7-segment driver.
// Revision: 1.0 - initial release
// ============================================================================
module seven_segment_mux_counter #(
  parameter int DIGITS         = 4,
  parameter int TICK_DIV       = 1000,
  parameter int SCAN_DIV       = 250,
  parameter bit ACTIVE_LOW_SEG = 1'b0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  i_en,
  input  logic                  i_up,
  input  logic                  i_dec_mode,
  input  logic                  i_blank_lz,
  input  logic                  i_load,
  input  logic [4*DIGITS-1:0]   i_load_val,
  output logic [4*DIGITS-1:0]   o_value,
  output logic                  o_wrap,
  output logic [DIGITS-1:0]     o_dig_sel,
  output logic [6:0]            o_seg
);

  localparam int c_VW = 4 * DIGITS;
  localparam int c_PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int c_SW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int c_IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  localparam logic [c_PW-1:0]   c_PRESC_MAX = c_PW'(TICK_DIV - 1);
  localparam logic [c_SW-1:0]   c_SCAN_MAX  = c_SW'(SCAN_DIV - 1);
  localparam logic [c_IW-1:0]   c_IDX_MAX   = c_IW'(DIGITS - 1);
  localparam logic [6:0]        c_SEG_INV   = {7{ACTIVE_LOW_SEG}};
  localparam logic [6:0]        c_GLYPH_0   = 7'h3F;
  localparam logic [DIGITS-1:0] c_SEL_RST   = DIGITS'(1);

  // Segment order {g,f,e,d,c,b,a}, lit = 1
  function automatic logic [6:0] f_glyph(input logic [3:0] i_nib);
    logic [6:0] w_g;
    case (i_nib)
      4'h0:    w_g = 7'h3F;
      4'h1:    w_g = 7'h06;
      4'h2:    w_g = 7'h5B;
      4'h3:    w_g = 7'h4F;
      4'h4:    w_g = 7'h66;
      4'h5:    w_g = 7'h6D;
      4'h6:    w_g = 7'h7D;
      4'h7:    w_g = 7'h07;
      4'h8:    w_g = 7'h7F;
      4'h9:    w_g = 7'h6F;
      4'hA:    w_g = 7'h77;
      4'hB:    w_g = 7'h7C;
      4'hC:    w_g = 7'h39;
      4'hD:    w_g = 7'h5E;
      4'hE:    w_g = 7'h79;
      default: w_g = 7'h71;
    endcase
    return w_g;
  endfunction

  logic [c_VW-1:0]   r_value;
  logic [c_PW-1:0]   r_presc;
  logic              r_wrap;
  logic [c_SW-1:0]   r_scan_cnt;
  logic [c_IW-1:0]   r_scan_idx;
  logic [DIGITS-1:0] r_dig_sel;
  logic [6:0]        r_seg;

  logic              w_tick;
  logic [c_VW-1:0]   w_hex_inc;
  logic [c_VW-1:0]   w_hex_dec;
  logic              w_hex_carry;
  logic [c_VW-1:0]   w_bcd_next;
  logic              w_bcd_carry;
  logic [c_VW-1:0]   w_load_sat;
  logic              w_scan_term;
  logic [c_IW-1:0]   w_idx_next;
  logic [DIGITS-1:0] w_onehot;
  logic [3:0]        w_sel_nib;
  logic              w_sel_blank;
  logic [6:0]        w_seg_next;

  assign w_tick      = i_en && (r_presc == c_PRESC_MAX);
  assign w_hex_inc   = r_value + c_VW'(1);
  assign w_hex_dec   = r_value - c_VW'(1);
  assign w_hex_carry = i_up ? (&r_value) : ~(|r_value);

  // BCD ripple; a non-decimal nibble participates as 9 only when the carry reaches it
  always_comb begin
    logic       w_c;
    logic [3:0] w_raw;
    logic [3:0] w_sat;
    w_bcd_next = r_value;
    w_c        = 1'b1;
    w_raw      = 4'd0;
    w_sat      = 4'd0;
    for (int k = 0; k < DIGITS; k++) begin
      w_raw = r_value[4*k +: 4];
      w_sat = (w_raw > 4'd9) ? 4'd9 : w_raw;
      if (w_c) begin
        if (i_up) begin
          w_bcd_next[4*k +: 4] = (w_sat == 4'd9) ? 4'd0 : w_sat + 4'd1;
          w_c                  = (w_sat == 4'd9);
        end else begin
          w_bcd_next[4*k +: 4] = (w_sat == 4'd0) ? 4'd9 : w_sat - 4'd1;
          w_c                  = (w_sat == 4'd0);
        end
      end
    end
    w_bcd_carry = w_c;
  end

  always_comb begin
    w_load_sat = i_load_val;
    for (int k = 0; k < DIGITS; k++) begin
      if (i_load_val[4*k +: 4] > 4'd9) begin
        w_load_sat[4*k +: 4] = 4'd9;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_value <= '0;
      r_presc <= '0;
      r_wrap  <= 1'b0;
    end else if (i_load) begin
      r_value <= i_dec_mode ? w_load_sat : i_load_val;
      r_presc <= '0;
      r_wrap  <= 1'b0;
    end else if (w_tick) begin
      r_value <= i_dec_mode ? w_bcd_next : (i_up ? w_hex_inc : w_hex_dec);
      r_presc <= '0;
      r_wrap  <= i_dec_mode ? w_bcd_carry : w_hex_carry;
    end else begin
      r_wrap <= 1'b0;
      if (i_en) begin
        r_presc <= r_presc + c_PW'(1);
      end
    end
  end

  assign w_scan_term = (r_scan_cnt == c_SCAN_MAX);
  assign w_idx_next  = !w_scan_term ? r_scan_idx :
                       (r_scan_idx == c_IDX_MAX) ? '0 : r_scan_idx + c_IW'(1);

  // Select and blanking look ahead to the digit about to be shown so seg tracks dig_sel
  always_comb begin
    w_onehot    = '0;
    w_sel_nib   = 4'd0;
    w_sel_blank = 1'b0;
    for (int k = 0; k < DIGITS; k++) begin
      if (int'(w_idx_next) == k) begin
        w_onehot[k] = 1'b1;
        w_sel_nib   = r_value[4*k +: 4];
        w_sel_blank = i_blank_lz && (k > 0) && ((r_value >> (4*k)) == '0);
      end
    end
  end

  assign w_seg_next = (w_sel_blank ? 7'h00 : f_glyph(w_sel_nib)) ^ c_SEG_INV;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_scan_cnt <= '0;
      r_scan_idx <= '0;
      r_dig_sel  <= c_SEL_RST;
      r_seg      <= c_GLYPH_0 ^ c_SEG_INV;
    end else begin
      r_scan_cnt <= w_scan_term ? '0 : r_scan_cnt + c_SW'(1);
      r_scan_idx <= w_idx_next;
      r_dig_sel  <= w_onehot;
      r_seg      <= w_seg_next;
    end
  end

  assign o_value   = r_value;
  assign o_wrap    = r_wrap;
  assign o_dig_sel = r_dig_sel;
  assign o_seg     = r_seg;

endmodule
`default_nettype wire

// File: tb/tb_seven_segment_mux_counter.sv
`default_nettype none
// ============================================================================
// Module  : tb_seven_segment_mux_counter
// Brief   : Scoreboard bench for seven_segment_mux_counter (2 digits, /3, /2).
// Revision: 1.0 - initial release
// ============================================================================
module tb_seven_segment_mux_counter;

  localparam int DIGITS   = 2;
  localparam int TICK_DIV = 3;
  localparam int SCAN_DIV = 2;

  logic       clk      = 1'b0;
  logic       rst_n    = 1'b1;
  logic       en       = 1'b0;
  logic       up       = 1'b0;
  logic       dec_mode = 1'b0;
  logic       blank_lz = 1'b0;
  logic       load     = 1'b0;
  logic [7:0] load_val = 8'h00;
  logic [7:0] value;
  logic       wrap;
  logic [1:0] dig_sel;
  logic [6:0] seg;

  seven_segment_mux_counter #(
    .DIGITS         (DIGITS),
    .TICK_DIV       (TICK_DIV),
    .SCAN_DIV       (SCAN_DIV),
    .ACTIVE_LOW_SEG (1'b0)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_en       (en),
    .i_up       (up),
    .i_dec_mode (dec_mode),
    .i_blank_lz (blank_lz),
    .i_load     (load),
    .i_load_val (load_val),
    .o_value    (value),
    .o_wrap     (wrap),
    .o_dig_sel  (dig_sel),
    .o_seg      (seg)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [7:0] v;
    logic       w;
    int         at;
  } exp_t;

  exp_t       q[$];
  logic [7:0] prev = 8'h00;

  task automatic push(input logic [7:0] v, input logic w, input int at);
    exp_t e;
    e.v  = v;
    e.w  = w;
    e.at = at;
    q.push_back(e);
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick_wait(input int n);
    repeat (n) begin
      @(negedge clk);
      #1;
    end
  endtask

  task automatic drain(input int max);
    int n;
    n = 0;
    while (q.size() != 0 && n < max) begin
      tick_wait(1);
      n++;
    end
    chk("sb_drain_pending", q.size(), 0);
    q.delete();
  endtask

  // Monitor: any change of value, or any wrap pulse, is a DUT output event
  always @(negedge clk) begin
    exp_t e;
    if (!rst_n) begin
      prev = value;
    end else if (value !== prev || wrap !== 1'b0) begin
      prev = value;
      checks++;
      if (q.size() == 0) begin
        errors++;
        $display("FAIL sb_unexpected: got value=%h wrap=%b at cycle %0d, expected no event",
                 value, wrap, cyc);
      end else begin
        e = q.pop_front();
        if (value !== e.v || wrap !== e.w || cyc != e.at) begin
          errors++;
          $display("FAIL sb_step: got value=%h wrap=%b cycle=%0d expected value=%h wrap=%b cycle=%0d",
                   value, wrap, cyc, e.v, e.w, e.at);
        end
      end
    end
  end

  task automatic scan_check(input int n, input logic [6:0] d1_exp, input string tag);
    logic [1:0] last;
    int         run;
    int         changes;
    last    = dig_sel;
    run     = 0;
    changes = 0;
    for (int i = 0; i < n; i++) begin
      tick_wait(1);
      if (dig_sel != last) begin
        if (changes > 0) chk({tag, "_dwell"}, run, 2);
        changes++;
        run  = 1;
        last = dig_sel;
      end else begin
        run++;
      end
      chk({tag, "_onehot"}, (dig_sel == 2'b01 || dig_sel == 2'b10), 1);
      chk({tag, "_seg"}, seg, (dig_sel == 2'b01) ? 7'h6D : d1_exp);
    end
    chk({tag, "_toggles"}, (changes >= n / 2 - 1), 1);
  endtask

  initial begin
    int c;
    // Power-on reset
    #1 rst_n = 1'b0;
    #2;
    chk("rst_value", value, 8'h00);
    chk("rst_dig_sel", dig_sel, 2'b01);
    chk("rst_seg", seg, 7'h3F);
    chk("rst_wrap", wrap, 1'b0);
    tick_wait(2);

    // Hex up from 00: one step per 3 clocks
    rst_n = 1'b1;
    up    = 1'b1;
    en    = 1'b1;
    c     = cyc;
    for (int i = 1; i <= 16; i++) push(8'(i), 1'b0, c + 3 * i);
    drain(80);
    chk("hex_after_16", value, 8'h10);

    // Hex wrap FF -> 00
    c = cyc;
    push(8'hFF, 1'b0, c + 1);
    push(8'h00, 1'b1, c + 4);
    push(8'h01, 1'b0, c + 7);
    load_val = 8'hFF;
    load     = 1'b1;
    tick_wait(1);
    load = 1'b0;
    drain(20);

    // BCD up wrap 99 -> 00, then down wrap 00 -> 99
    c = cyc;
    dec_mode = 1'b1;
    load_val = 8'h99;
    load     = 1'b1;
    push(8'h99, 1'b0, c + 1);
    push(8'h00, 1'b1, c + 4);
    push(8'h99, 1'b1, c + 7);
    push(8'h98, 1'b0, c + 10);
    tick_wait(1);
    load = 1'b0;
    tick_wait(3);
    up = 1'b0;
    drain(20);

    // BCD load clamp 3C -> 39, down step, then load colliding with a tick
    c = cyc;
    load_val = 8'h3C;
    load     = 1'b1;
    push(8'h39, 1'b0, c + 1);
    push(8'h38, 1'b0, c + 4);
    push(8'h42, 1'b0, c + 7);
    push(8'h43, 1'b0, c + 10);
    tick_wait(1);
    load = 1'b0;
    tick_wait(5);
    load_val = 8'h42;
    load     = 1'b1;
    up       = 1'b1;
    tick_wait(1);
    load = 1'b0;
    drain(20);

    // Scan and leading-zero blanking on 05
    c = cyc;
    en       = 1'b0;
    blank_lz = 1'b1;
    load_val = 8'h05;
    load     = 1'b1;
    push(8'h05, 1'b0, c + 1);
    tick_wait(1);
    load = 1'b0;
    drain(5);
    tick_wait(2);
    scan_check(8, 7'h00, "blank");
    blank_lz = 1'b0;
    tick_wait(2);
    scan_check(6, 7'h3F, "noblank");

    // Hold mid-prescale for 10 clocks while scanning continues
    c = cyc;
    push(8'h06, 1'b0, c + 13);
    en = 1'b1;
    tick_wait(1);
    en = 1'b0;
    scan_check(10, 7'h3F, "hold");
    en = 1'b1;
    drain(10);

    // Asynchronous reset mid-run
    rst_n = 1'b0;
    #1;
    chk("arst_value", value, 8'h00);
    chk("arst_dig_sel", dig_sel, 2'b01);
    chk("arst_seg", seg, 7'h3F);
    chk("arst_wrap", wrap, 1'b0);
    en = 1'b0;
    tick_wait(1);
    rst_n = 1'b1;
    tick_wait(4);
    chk("final_value", value, 8'h00);
    chk("sb_final_empty", q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
